fill_sequencer: RTL

FILL_SEQUENCER -- requirements
Module: fill_sequencer

---
 rtl/fill_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/fill_sequencer.sv
// Bottle fill/seal/count sequencer with registered Moore outputs.
// Optional FILL-state watchdog enabled by defining FILL_TIMEOUT_EN.
module fill_sequencer #(
    parameter int unsigned SEAL_CYCLES  = 4,
    parameter int unsigned FILL_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       bottle_sensor,
    input  logic       level_sensor,
    input  logic [7:0] stock,
    output logic       conveyor,
    output logic       valve,
    output logic       sealer,
    output logic       consume,
    output logic       dozen,
    output logic [7:0] bottle_count,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        FILL  = 3'd2,
        SEAL  = 3'd3,
        COUNT = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [3:0] SEAL_LAST  = 4'(SEAL_CYCLES - 1);
    localparam logic [7:0] FILL_LIMIT = 8'(FILL_TIMEOUT);
`ifdef FILL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t     cur;
    state_t     nxt;
    logic [3:0] seal_cnt;
    logic [7:0] fill_cnt;
    logic [3:0] dozen_cnt;
    logic       stop_latch;
    logic       fill_expired;

    // Counter always exists; the watchdog only acts when TIMEOUT_EN is set.
    assign fill_expired = TIMEOUT_EN && ((fill_cnt + 8'd1) == FILL_LIMIT);
    assign state        = cur;

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (start && !stop && (stock != 8'd0)) nxt = FEED;
            FEED:    if (stop) nxt = IDLE;
                     else if (bottle_sensor) nxt = FILL;
            FILL:    if (level_sensor) nxt = SEAL;
                     else if (fill_expired) nxt = ERROR;
            SEAL:    if (seal_cnt == SEAL_LAST) nxt = COUNT;
            COUNT:   if (stop_latch || !start || (stock <= 8'd1)) nxt = IDLE;
                     else nxt = FEED;
            ERROR:   if (clear) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur          <= IDLE;
            conveyor     <= 1'b0;
            valve        <= 1'b0;
            sealer       <= 1'b0;
            consume      <= 1'b0;
            dozen        <= 1'b0;
            error        <= 1'b0;
            bottle_count <= '0;
            dozen_cnt    <= '0;
            seal_cnt     <= '0;
            fill_cnt     <= '0;
            stop_latch   <= 1'b0;
        end else begin
            cur      <= nxt;
            conveyor <= (nxt == FEED);
            valve    <= (nxt == FILL);
            sealer   <= (nxt == SEAL);
            consume  <= (nxt == COUNT);
            error    <= (nxt == ERROR);

            seal_cnt <= (cur == SEAL && nxt == SEAL) ? seal_cnt + 4'd1 : '0;
            fill_cnt <= (cur == FILL && nxt == FILL) ? fill_cnt + 8'd1 : '0;

            if (nxt == IDLE)
                stop_latch <= 1'b0;
            else if (stop && (cur == FILL || cur == SEAL))
                stop_latch <= 1'b1;

            if (nxt == COUNT) begin
                bottle_count <= bottle_count + 8'd1;
                if (dozen_cnt == 4'd11) begin
                    dozen_cnt <= '0;
                    dozen     <= 1'b1;
                end else begin
                    dozen_cnt <= dozen_cnt + 4'd1;
                    dozen     <= 1'b0;
                end
            end else begin
                dozen <= 1'b0;
            end
        end
    end

endmodule
